// File: rtl/dac_tx_pkg.sv
// rtl/dac_tx_pkg.sv - shared types, sizes and frame packing for the DAC playback path
package dac_tx_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FRAME, GAP} play_state_t;

  localparam int FRAME_W          = 24;
  localparam int BYTES_PER_SAMPLE = 8;
  localparam int CH_NUM           = 4;
  localparam int CH_W             = 16;

  // Channel 0 (ch1) lives in the top 16 bits of the sample word.
  function automatic logic [FRAME_W-1:0] dac_frame(
    input logic [3:0]             cmd,
    input logic [1:0]             ch_idx,
    input logic [CH_NUM*CH_W-1:0] word
  );
    logic [CH_W-1:0] ch;
    ch = word[(CH_NUM - 1 - int'(ch_idx)) * CH_W +: CH_W];
    return {cmd, {2'b00, ch_idx}, ch};
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - mode-0 SPI frame shifter with chip-select gap and done strobes
module spi_frame_tx import dac_tx_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               cs_n,
  output logic               sclk,
  output logic               sdi,
  output logic               shift_done,
  output logic               gap_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} phase_t;

  phase_t             phase;
  logic [FRAME_W-1:0] sh;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BIT_W-1:0]   rise_cnt;
  logic               div_hit;
  logic               start_shift;

  assign div_hit     = div_cnt == DIV_W'(CLK_DIV - 1);
  assign shift_done  = phase == S_SHIFT && div_hit && sclk && rise_cnt == BIT_W'(FRAME_W);
  assign gap_done    = phase == S_GAP && gap_cnt == GAP_W'(CS_GAP - 1);
  assign start_shift = load && (phase == S_IDLE || gap_done);
  assign sdi         = sh[FRAME_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= S_IDLE;
      sh       <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      rise_cnt <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
    end else if (start_shift) begin
      phase    <= S_SHIFT;
      sh       <= frame;
      cs_n     <= 1'b0;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      rise_cnt <= '0;
    end else begin
      case (phase)
        S_SHIFT: begin
          if (div_hit) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk     <= 1'b1;
              rise_cnt <= rise_cnt + 1'b1;
            end else if (shift_done) begin
              // final falling edge doubles as the chip-select release
              sclk    <= 1'b0;
              cs_n    <= 1'b1;
              sh      <= '0;
              gap_cnt <= '0;
              phase   <= S_GAP;
            end else begin
              sclk <= 1'b0;
              sh   <= {sh[FRAME_W-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_done) phase <= S_IDLE;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        default: phase <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dma_axis_dac_tx.sv
// rtl/dma_axis_dac_tx.sv - byte-stream sample reassembly and timed 4-channel SPI DAC playback
module dma_axis_dac_tx import dac_tx_pkg::*; #(
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 500,
  parameter logic [3:0] DAC_CMD       = 4'h3,
  parameter int         CS_GAP        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] play_len,
  input  logic        play_start,
  output logic        busy,
  output logic        underrun,
  output logic        tlast_err,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi
);

  localparam int WORD_W = CH_NUM * CH_W;

  play_state_t        state, state_nxt;
  logic [31:0]        len_r, acc_cnt, play_cnt, tick_cnt;
  logic [2:0]         byte_cnt;
  logic [WORD_W-9:0]  asm_r;
  logic [WORD_W-1:0]  hold_r, play_word;
  logic               hold_full;
  logic [1:0]         ch_idx;
  logic               start_ok, xfer, last_byte, tlast_exp, tick, take;
  logic               load, shift_done, gap_done;
  logic [FRAME_W-1:0] frame;
  logic               unused_tkeep;

  assign unused_tkeep  = s_axis_tkeep;
  assign busy          = state != IDLE;
  assign start_ok      = play_start && !busy && play_len != 32'd0;
  assign s_axis_tready = busy && !hold_full && acc_cnt < len_r;
  assign xfer          = s_axis_tvalid && s_axis_tready;
  assign last_byte     = byte_cnt == 3'(BYTES_PER_SAMPLE - 1);
  assign tlast_exp     = last_byte && acc_cnt == len_r - 32'd1;
  assign tick          = busy && tick_cnt == 32'(SAMPLE_PERIOD - 1);
  assign take          = tick && state == WAIT && hold_full;

  // The first frame of a sample is loaded from hold_r, since play_word only updates at that edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    frame     = dac_frame(DAC_CMD, ch_idx, play_word);
    case (state)
      IDLE:  if (start_ok) state_nxt = WAIT;
      WAIT:  if (take) begin
        state_nxt = FRAME;
        load      = 1'b1;
        frame     = dac_frame(DAC_CMD, 2'd0, hold_r);
      end
      FRAME: if (shift_done) state_nxt = GAP;
      GAP:   if (gap_done) begin
        if (ch_idx != 2'(CH_NUM - 1)) begin
          state_nxt = FRAME;
          load      = 1'b1;
          frame     = dac_frame(DAC_CMD, ch_idx + 2'd1, play_word);
        end else if (play_cnt == len_r) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      acc_cnt   <= '0;
      play_cnt  <= '0;
      tick_cnt  <= '0;
      byte_cnt  <= '0;
      asm_r     <= '0;
      hold_r    <= '0;
      play_word <= '0;
      hold_full <= 1'b0;
      ch_idx    <= '0;
      underrun  <= 1'b0;
      tlast_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_r     <= play_len;
        acc_cnt   <= '0;
        play_cnt  <= '0;
        tick_cnt  <= '0;
        byte_cnt  <= '0;
        asm_r     <= '0;
        hold_full <= 1'b0;
        ch_idx    <= '0;
        underrun  <= 1'b0;
        tlast_err <= 1'b0;
      end else begin
        if (busy) tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
        if (xfer) begin
          if (s_axis_tlast != tlast_exp) tlast_err <= 1'b1;
          if (last_byte) begin
            hold_r    <= {s_axis_tdata, asm_r};
            hold_full <= 1'b1;
            acc_cnt   <= acc_cnt + 32'd1;
            byte_cnt  <= '0;
          end else begin
            asm_r[{byte_cnt, 3'b000} +: 8] <= s_axis_tdata;
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        if (take) begin
          play_word <= hold_r;
          hold_full <= 1'b0;
          ch_idx    <= '0;
        end
        if (tick && state == WAIT && !hold_full) underrun <= 1'b1;
        if (state == FRAME && shift_done && ch_idx == 2'(CH_NUM - 1)) play_cnt <= play_cnt + 32'd1;
        if (state == GAP && gap_done && ch_idx != 2'(CH_NUM - 1)) ch_idx <= ch_idx + 2'd1;
      end
    end
  end

  spi_frame_tx #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_spi (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .frame      (frame),
    .cs_n       (dac_cs_n),
    .sclk       (dac_sclk),
    .sdi        (dac_sdi),
    .shift_done (shift_done),
    .gap_done   (gap_done)
  );

endmodule

// File: tb/tb_dma_axis_dac_tx.sv
// tb/tb_dma_axis_dac_tx.sv - directed scoreboard bench for dma_axis_dac_tx
module tb_dma_axis_dac_tx;

  localparam int         CLK_DIV       = 2;
  localparam int         SAMPLE_PERIOD = 500;
  localparam int         CS_GAP        = 2;
  localparam logic [3:0] DAC_CMD       = 4'h3;
  localparam int         LIMIT         = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] play_len = '0;
  logic        play_start = 1'b0;
  logic        busy, underrun, tlast_err;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tkeep = 1'b1;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        dac_cs_n, dac_sclk, dac_sdi;

  always #5 clk = ~clk;

  dma_axis_dac_tx #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .DAC_CMD       (DAC_CMD),
    .CS_GAP        (CS_GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play_len      (play_len),
    .play_start    (play_start),
    .busy          (busy),
    .underrun      (underrun),
    .tlast_err     (tlast_err),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dac_cs_n      (dac_cs_n),
    .dac_sclk      (dac_sclk),
    .dac_sdi       (dac_sdi)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  int          frames_seen = 0;
  int          xfers = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        in_frame = 1'b0;
  logic [23:0] rx = '0;
  int          rx_bits = 0;
  int          low_cyc = 0;
  int          high_cyc = 1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SPI decoder and stream transfer counter, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (s_axis_tvalid && s_axis_tready) xfers++;
    if (rst) begin
      in_frame = 1'b0;
      rx_bits  = 0;
      high_cyc = 1000;
    end else if (!dac_cs_n) begin
      if (prev_cs) begin
        check("cs_gap_min", high_cyc >= CS_GAP, 1);
        in_frame = 1'b1;
        rx_bits  = 0;
        low_cyc  = 0;
      end
      low_cyc++;
      if (dac_sclk && !prev_sclk) begin
        rx = {rx[22:0], dac_sdi};
        rx_bits++;
      end
    end else begin
      if (!prev_cs && in_frame) begin
        check("frame_bits", rx_bits, 24);
        check("cs_low_cycles", low_cyc, 48 * CLK_DIV);
        check("sclk_low_at_cs_rise", dac_sclk, 0);
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("frame_data", rx, exp_q.pop_front());
        frames_seen++;
        in_frame = 1'b0;
        high_cyc = 0;
      end
      high_cyc++;
    end
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
  end

  task automatic start(input logic [31:0] len);
    play_len   = len;
    play_start = 1'b1;
    @(posedge clk); #1;
    play_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("tready_wait", n < LIMIT, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_sample(input logic [63:0] w, input logic tl7);
    for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], tl7 && k == 7);
  endtask

  task automatic expect_sample(input logic [63:0] w);
    for (int n = 0; n < 4; n++) exp_q.push_back({DAC_CMD, 4'(n), w[16*(3-n) +: 16]});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < LIMIT, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int          f0, x0, n;
    logic [63:0] w [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_tlast_err", tlast_err, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_sdi", dac_sdi, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single sample, bytes 00..07
    exp_q.push_back(24'h300706);
    exp_q.push_back(24'h310504);
    exp_q.push_back(24'h320302);
    exp_q.push_back(24'h330100);
    f0 = frames_seen;
    start(1);
    check("t1_busy_after_start", busy, 1);
    for (int k = 0; k < 8; k++) send_byte(8'(k), k == 7);
    wait_idle("t1_idle_timeout");
    check("t1_frames", frames_seen - f0, 4);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_underrun", underrun, 0);
    check("t1_tlast_err", tlast_err, 0);

    // four samples back to back, then one extra byte left pending
    for (int i = 0; i < 4; i++) begin
      w[i] = {$urandom, $urandom};
      expect_sample(w[i]);
    end
    f0 = frames_seen;
    x0 = xfers;
    start(4);
    for (int i = 0; i < 4; i++) send_sample(w[i], i == 3);
    s_axis_tdata  = 8'hAA;
    s_axis_tvalid = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_busy_while_draining", busy, 1);
    check("t2_tready_after_len", s_axis_tready, 0);
    wait_idle("t2_idle_timeout");
    check("t2_bytes_accepted", xfers - x0, 32);
    check("t2_frames", frames_seen - f0, 16);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_underrun", underrun, 0);
    check("t2_tlast_err", tlast_err, 0);
    check("t2_byte_still_pending", s_axis_tvalid && !s_axis_tready, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;

    // source stall forces an underrun before sample 2
    for (int i = 0; i < 3; i++) begin
      w[i] = {$urandom, $urandom};
      expect_sample(w[i]);
    end
    f0 = frames_seen;
    start(3);
    send_sample(w[0], 1'b0);
    send_sample(w[1], 1'b0);
    check("t3_no_underrun_yet", underrun, 0);
    repeat (2 * SAMPLE_PERIOD + 20) @(posedge clk);
    #1;
    check("t3_underrun_set", underrun, 1);
    check("t3_busy_during_stall", busy, 1);
    send_sample(w[2], 1'b1);
    wait_idle("t3_idle_timeout");
    check("t3_frames", frames_seen - f0, 12);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_underrun_sticky", underrun, 1);
    check("t3_tlast_err", tlast_err, 0);

    // early tlast on sample 0 of two
    for (int i = 0; i < 2; i++) begin
      w[i] = {$urandom, $urandom};
      expect_sample(w[i]);
    end
    f0 = frames_seen;
    start(2);
    send_sample(w[0], 1'b1);
    check("t4_tlast_err_set", tlast_err, 1);
    send_sample(w[1], 1'b1);
    wait_idle("t4_idle_timeout");
    check("t4_frames", frames_seen - f0, 8);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_tlast_err_sticky", tlast_err, 1);
    w[0] = 64'h8899AABBCCDDEEFF;
    expect_sample(w[0]);
    f0 = frames_seen;
    start(1);
    check("t4_tlast_err_cleared", tlast_err, 0);
    check("t4_underrun_cleared", underrun, 0);
    send_sample(w[0], 1'b1);
    wait_idle("t4b_idle_timeout");
    check("t4b_frames", frames_seen - f0, 4);
    check("t4b_tlast_err", tlast_err, 0);

    // reset in the middle of a frame
    w[0] = {$urandom, $urandom};
    start(1);
    send_sample(w[0], 1'b1);
    n = 0;
    while (!(rx_bits >= 10 && !dac_cs_n) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_bit10", n < LIMIT, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_cs_n", dac_cs_n, 1);
    check("t5_sclk", dac_sclk, 0);
    check("t5_busy", busy, 0);
    check("t5_tready", s_axis_tready, 0);
    exp_q.delete();
    w[0] = 64'h0123456789ABCDEF;
    expect_sample(w[0]);
    f0 = frames_seen;
    @(posedge clk); #1;
    start(1);
    send_sample(w[0], 1'b1);
    wait_idle("t5_idle_timeout");
    check("t5_frames", frames_seen - f0, 4);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_tlast_err", tlast_err, 0);

    // ignored starts
    start(0);
    @(negedge clk);
    check("t6_len0_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("t6_len0_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      w[i] = {$urandom, $urandom};
      expect_sample(w[i]);
    end
    f0 = frames_seen;
    x0 = xfers;
    start(2);
    send_sample(w[0], 1'b0);
    start(5);
    check("t6_busy_after_restart", busy, 1);
    send_sample(w[1], 1'b1);
    wait_idle("t6_idle_timeout");
    check("t6_frames", frames_seen - f0, 8);
    check("t6_bytes", xfers - x0, 16);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_tlast_err", tlast_err, 0);
    check("t6_underrun", underrun, 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
